// File: rtl/drum_step_seq.sv
// Four-voice, eight-step drum pattern sequencer with per-voice trigger pulse stretchers.
// Define DRUM_SEQ_PRESET_EN to reset the pattern to a basic kick/snare/hat groove instead of all zeros.
module drum_step_seq #(
    parameter int unsigned TRIG_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en,
    input  logic       run,
    input  logic [2:0] len,
    input  logic       wr_en,
    input  logic [1:0] wr_voice,
    input  logic [2:0] wr_step,
    input  logic       wr_val,
    output logic [3:0] trig,
    output logic [2:0] step_idx,
    output logic       bar_pulse
);

    // state | meaning
    // IDLE  | stopped, outputs quiet, waiting for run
    // ARMED | run asserted, waiting for the first step_en (plays step 0)
    // PLAY  | each step_en advances the index and fires that step's voices
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2
    } state_t;

    localparam int          NUM_VOICES = 4;
    localparam logic [19:0] TRIG_LOAD  = 20'(TRIG_CYCLES);

`ifdef DRUM_SEQ_PRESET_EN
    // voice3 none, voice2 every step, voice1 steps 2/6, voice0 steps 0/4
    localparam logic [3:0][7:0] PATTERN_RST = {8'h00, 8'hFF, 8'h44, 8'h11};
`else
    localparam logic [3:0][7:0] PATTERN_RST = '0;
`endif

    state_t           state_q,   state_d;
    logic [2:0]       idx_q,     idx_d;
    logic             bar_q,     bar_d;
    logic [3:0][7:0]  pattern_q, pattern_d;
    logic [19:0]      cnt_q [NUM_VOICES];
    logic [19:0]      cnt_d [NUM_VOICES];

    logic             play;
    logic [2:0]       play_step;
    logic             stop;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bar_d     = 1'b0;
        pattern_d = pattern_q;
        play      = 1'b0;
        play_step = idx_q;
        stop      = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            cnt_d[v] = (cnt_q[v] != 20'd0) ? cnt_q[v] - 20'd1 : 20'd0;
        end

        case (state_q)
            IDLE: begin
                stop = 1'b1;
                if (run) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!run) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end else if (step_en) begin
                    state_d   = PLAY;
                    play      = 1'b1;
                    play_step = 3'd0;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end else if (step_en) begin
                    play      = 1'b1;
                    // a length shrunk below the current index wraps straight to step 0
                    play_step = (idx_q >= len) ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                stop    = 1'b1;
            end
        endcase

        if (stop) begin
            idx_d = 3'd0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                cnt_d[v] = 20'd0;
            end
        end

        // play reads pattern_q, so a coinciding write only affects later passes
        if (play) begin
            idx_d = play_step;
            bar_d = (play_step == 3'd0);
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (pattern_q[v][play_step]) begin
                    cnt_d[v] = TRIG_LOAD;
                end
            end
        end

        if (wr_en) begin
            pattern_d[wr_voice][wr_step] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            bar_q     <= 1'b0;
            pattern_q <= PATTERN_RST;
            for (int v = 0; v < NUM_VOICES; v++) begin
                cnt_q[v] <= 20'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bar_q     <= bar_d;
            pattern_q <= pattern_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                cnt_q[v] <= cnt_d[v];
            end
        end
    end

    always_comb begin
        trig = 4'd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            trig[v] = (cnt_q[v] != 20'd0);
        end
    end

    assign step_idx  = idx_q;
    assign bar_pulse = bar_q;

endmodule

// File: tb/tb_drum_step_seq.sv
// Self-checking bench for drum_step_seq: hand-written vector table, directed corner sequences,
// and randomized traffic compared against a timestamp-based reference model.
module tb_drum_step_seq;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_en = 1'b0;
    logic       run = 1'b0;
    logic [2:0] len = 3'd0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_voice = 2'd0;
    logic [2:0] wr_step = 3'd0;
    logic       wr_val = 1'b0;
    logic [3:0] trig;
    logic [2:0] step_idx;
    logic       bar_pulse;

    drum_step_seq #(.TRIG_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .step_en(step_en), .run(run), .len(len),
        .wr_en(wr_en), .wr_voice(wr_voice), .wr_step(wr_step), .wr_val(wr_val),
        .trig(trig), .step_idx(step_idx), .bar_pulse(bar_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: playback mode (0 stopped, 1 waiting, 2 playing), the cycle
    // each voice was last fired and the cycle of the last bar start.
    int m_mode;
    int m_idx;
    int cyc = 0;
    int last_play [4];
    int bar_at;
    bit m_pat [4][8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_idx  = 0;
        bar_at = -100;
        for (int v = 0; v < 4; v++) begin
            last_play[v] = -100;
            for (int s = 0; s < 8; s++) begin
`ifdef DRUM_SEQ_PRESET_EN
                m_pat[v][s] = (v == 0 && s % 4 == 0) || (v == 1 && s % 4 == 2) || (v == 2);
`else
                m_pat[v][s] = 1'b0;
`endif
            end
        end
    endfunction

    function automatic void model_step();
        int s;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_mode != 0 && !run) begin
            m_mode = 0;
            m_idx  = 0;
            for (int v = 0; v < 4; v++) last_play[v] = -100;
        end else if (m_mode == 0) begin
            if (run) m_mode = 1;
        end else if (step_en) begin
            if (m_mode == 1) begin
                s = 0;
                m_mode = 2;
            end else begin
                s = (m_idx >= int'(len)) ? 0 : m_idx + 1;
            end
            m_idx = s;
            for (int v = 0; v < 4; v++) if (m_pat[v][s]) last_play[v] = cyc;
            if (s == 0) bar_at = cyc;
        end
        if (wr_en) m_pat[wr_voice][wr_step] = wr_val;
    endfunction

    task automatic tick();
        logic [3:0] exp_trig;
        @(posedge clk);
        model_step();
        #1;
        for (int v = 0; v < 4; v++) exp_trig[v] = (cyc - last_play[v]) < T;
        chk("model_trig", int'(trig), int'(exp_trig));
        chk("model_step_idx", int'(step_idx), m_idx);
        chk("model_bar_pulse", int'(bar_pulse), int'(bar_at == cyc));
    endtask

    task automatic do_reset();
        reset = 1'b1; step_en = 1'b0; run = 1'b0; wr_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cell(input int v, input int s, input bit val);
        wr_en = 1'b1; wr_voice = 2'(v); wr_step = 3'(s); wr_val = val;
        tick();
        wr_en = 1'b0;
    endtask

    typedef struct {
        bit       run;
        bit       step_en;
        bit       wr_en;
        int       wr_voice;
        int       wr_step;
        bit       wr_val;
        int       exp_trig;
        int       exp_idx;
        bit       exp_bar;
    } vec_t;

    vec_t tbl [14];

    int rises [4];
    int bars;
    logic [3:0] prev_trig;

    initial begin
        // len=1: step 0 fires kick, step 1 fires snare; hat cells cleared so both builds agree
        tbl[0]  = '{0, 0, 1, 0, 0, 1, 4'b0000, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 1, 1, 4'b0000, 0, 0};
        tbl[2]  = '{1, 0, 1, 2, 0, 0, 4'b0000, 0, 0};
        tbl[3]  = '{1, 0, 1, 2, 1, 0, 4'b0000, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 0, 4'b0001, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 4'b0001, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 0, 4'b0011, 1, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 4'b0011, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 4'b0010, 1, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 4'b0011, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 4'b0000, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 4'b0000, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 4'b0000, 0, 0};
        tbl[13] = '{1, 1, 0, 0, 0, 0, 4'b0001, 0, 1};

        #1;
        do_reset();
        chk("reset_trig", int'(trig), 0);
        chk("reset_step_idx", int'(step_idx), 0);
        chk("reset_bar", int'(bar_pulse), 0);

        len = 3'd1;
        for (int i = 0; i < 14; i++) begin
            run = tbl[i].run; step_en = tbl[i].step_en; wr_en = tbl[i].wr_en;
            wr_voice = 2'(tbl[i].wr_voice); wr_step = 3'(tbl[i].wr_step); wr_val = tbl[i].wr_val;
            tick();
            chk($sformatf("tbl%0d_trig", i), int'(trig), tbl[i].exp_trig);
            chk($sformatf("tbl%0d_idx", i), int'(step_idx), tbl[i].exp_idx);
            chk($sformatf("tbl%0d_bar", i), int'(bar_pulse), int'(tbl[i].exp_bar));
        end
        step_en = 1'b0; wr_en = 1'b0;

        // groove: kick 0/4, snare 2/6, hat all, 16 steps every 10 cycles
        do_reset();
        for (int s = 0; s < 8; s++) begin
            write_cell(0, s, s % 4 == 0);
            write_cell(1, s, s % 4 == 2);
            write_cell(2, s, 1'b1);
            write_cell(3, s, 1'b0);
        end
        run = 1'b1; len = 3'd7;
        tick();
        for (int v = 0; v < 4; v++) rises[v] = 0;
        bars = 0;
        prev_trig = trig;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < 10; c++) begin
                step_en = (c == 0);
                tick();
                for (int v = 0; v < 4; v++) if (trig[v] && !prev_trig[v]) rises[v]++;
                if (bar_pulse) bars++;
                prev_trig = trig;
            end
        end
        step_en = 1'b0;
        chk("groove_kick_rises", rises[0], 4);
        chk("groove_snare_rises", rises[1], 4);
        chk("groove_hat_rises", rises[2], 16);
        chk("groove_aux_rises", rises[3], 0);
        chk("groove_bars", bars, 2);

        // write coinciding with play of the same cell uses the old value
        do_reset();
        run = 1'b1; len = 3'd7;
        tick();
        step_en = 1'b1; tick(); step_en = 1'b0; tick();
        step_en = 1'b1; wr_en = 1'b1; wr_voice = 2'd3; wr_step = 3'd1; wr_val = 1'b1;
        tick();
        step_en = 1'b0; wr_en = 1'b0;
        chk("wr_race_idx", int'(step_idx), 1);
        chk("wr_race_aux_quiet", int'(trig[3]), 0);
        tick();
        for (int n = 0; n < 7; n++) begin
            step_en = 1'b1; tick(); step_en = 1'b0; tick();
        end
        step_en = 1'b1; tick(); step_en = 1'b0;
        chk("wr_next_pass_idx", int'(step_idx), 1);
        chk("wr_next_pass_aux", int'(trig[3]), 1);
        tick();

        // length shrink below current index
        do_reset();
        run = 1'b1; len = 3'd2;
        tick();
        for (int n = 0; n < 3; n++) begin
            step_en = 1'b1; tick(); step_en = 1'b0; tick();
        end
        chk("len_before_idx", int'(step_idx), 2);
        len = 3'd0;
        for (int n = 0; n < 3; n++) begin
            step_en = 1'b1; tick();
            chk($sformatf("len0_idx_%0d", n), int'(step_idx), 0);
            chk($sformatf("len0_bar_%0d", n), int'(bar_pulse), 1);
            step_en = 1'b0; tick();
        end

        // retrigger without a low gap
        do_reset();
        for (int s = 0; s < 8; s++) write_cell(0, s, 1'b1);
        run = 1'b1; len = 3'd7;
        tick();
        for (int n = 0; n < 6; n++) begin
            step_en = 1'b1; tick();
            chk($sformatf("retrig_hi_a%0d", n), int'(trig[0]), 1);
            step_en = 1'b0; tick();
            chk($sformatf("retrig_hi_b%0d", n), int'(trig[0]), 1);
        end
        tick(); chk("retrig_tail2", int'(trig[0]), 1);
        tick(); chk("retrig_tail3", int'(trig[0]), 1);
        tick(); chk("retrig_fall", int'(trig[0]), 0);

        // stop and reset mid-trigger
        do_reset();
        write_cell(2, 0, 1'b1);
        write_cell(2, 1, 1'b1);
        run = 1'b1; len = 3'd7;
        tick();
        step_en = 1'b1; tick(); step_en = 1'b0; tick();
        step_en = 1'b1; tick(); step_en = 1'b0;
        chk("stop_pre_trig", int'(trig[2]), 1);
        run = 1'b0; tick();
        chk("stop_trig", int'(trig), 0);
        chk("stop_idx", int'(step_idx), 0);
        run = 1'b1; tick();
        step_en = 1'b1; tick(); step_en = 1'b0; tick();
        step_en = 1'b1; tick(); step_en = 1'b0;
        chk("rst_pre_idx", int'(step_idx), 1);
        reset = 1'b1; wr_en = 1'b1; wr_voice = 2'd3; wr_step = 3'd0; wr_val = 1'b1; step_en = 1'b1;
        tick();
        reset = 1'b0; wr_en = 1'b0; step_en = 1'b0;
        chk("rst_trig", int'(trig), 0);
        chk("rst_idx", int'(step_idx), 0);
        tick();
        step_en = 1'b1; tick(); step_en = 1'b0;
        chk("restart_idx", int'(step_idx), 0);
        chk("restart_bar", int'(bar_pulse), 1);
        chk("restart_aux_blocked", int'(trig[3]), 0);
        tick();

        // randomized traffic against the model
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) run = ~run;
            step_en = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 4) == 0);
            wr_voice = 2'($urandom_range(0, 3));
            wr_step  = 3'($urandom_range(0, 7));
            wr_val   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) len = 3'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0; step_en = 1'b0; wr_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
